// File: rtl/pc_gen_if.sv
// pc_gen_if: request and fetch-address bundle for the PC generator.
// The slave modport is the PC generator; the master modport is the
// surrounding pipeline (trap unit, decode, execute, fetch).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            pc_en;
    logic            trap_en;
    logic [XLEN-1:0] trap_addr;
    logic            ex_redir_en;
    logic            ex_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [12:0]     ex_off;
    logic            id_jal_en;
    logic [XLEN-1:0] id_pc;
    logic [20:0]     id_off;
    logic            id_call;
    logic            id_ret_en;
    logic [XLEN-1:0] pc_addr;
    logic            redirect;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    logic            ras_hit;

    modport master (
        output pc_en, trap_en, trap_addr, ex_redir_en, ex_jalr, ex_pc, ex_rs1,
               ex_off, id_jal_en, id_pc, id_off, id_call, id_ret_en,
        input  pc_addr, redirect, misalign_err, misalign_addr, ras_hit
    );

    modport slave (
        input  pc_en, trap_en, trap_addr, ex_redir_en, ex_jalr, ex_pc, ex_rs1,
               ex_off, id_jal_en, id_pc, id_off, id_call, id_ret_en,
        output pc_addr, redirect, misalign_err, misalign_addr, ras_hit
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Picks the next fetch address from trap, execute redirect, return-address
// prediction, decode JAL or sequential increment. Redirect targets are
// computed from the redirecting instruction's own PC. Misaligned ex/JAL
// targets are dropped and reported.
// Optional return-address stack: define PC_GEN_RAS_EN to build it.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_if.slave     bus
);

    localparam logic [XLEN-1:0] TRAP_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] pcAddr_q, pcAddr_d;
    logic            redirect_q, redirect_d;
    logic            misalignErr_q, misalignErr_d;
    logic [XLEN-1:0] misalignAddr_q, misalignAddr_d;
    logic            rasHit_q, rasHit_d;

    logic [XLEN-1:0] exOffExt;
    logic [XLEN-1:0] idOffExt;
    logic [XLEN-1:0] exTarget;
    logic [XLEN-1:0] idTarget;
    logic [XLEN-1:0] callLink;
    logic            rasFlush;
    logic            idAccept;
    logic            rasPopOk;
    logic [XLEN-1:0] rasTop;

    assign exOffExt = {{(XLEN-13){bus.ex_off[12]}}, bus.ex_off};
    assign idOffExt = {{(XLEN-21){bus.id_off[20]}}, bus.id_off};
    assign exTarget = bus.ex_jalr ? ((bus.ex_rs1 + exOffExt) & JALR_MASK)
                                  : (bus.ex_pc + exOffExt);
    assign idTarget = bus.id_pc + idOffExt;
    assign callLink = bus.id_pc + XLEN'(4);

`ifdef PC_GEN_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] rasMem_q [RAS_DEPTH];
    logic [PW-1:0]   rasTos_q;
    logic [CW-1:0]   rasCount_q;
    logic            rasPop;
    logic            rasPush;
    logic [PW-1:0]   rasWrIdx;

    assign rasPopOk = bus.id_ret_en && (rasCount_q != '0);
    assign rasTop   = rasMem_q[rasTos_q];
    assign rasPop   = idAccept && rasPopOk;
    // A call pushes only when the decode instruction actually redirects:
    // either the combined pop/push return, or an aligned JAL that wins.
    assign rasPush  = idAccept && bus.id_call &&
                      ((bus.id_ret_en && rasPopOk) ||
                       (bus.id_jal_en && !rasPopOk && !idTarget[1]));
    assign rasWrIdx = rasPop ? rasTos_q : rasTos_q + PW'(1);

    // Stack pointer and occupancy; pop+push replaces the top in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rasTos_q   <= '0;
            rasCount_q <= '0;
        end else if (rasFlush) begin
            rasCount_q <= '0;
        end else if (rasPush && !rasPop) begin
            rasTos_q <= rasTos_q + PW'(1);
            if (rasCount_q != CW'(RAS_DEPTH)) begin
                rasCount_q <= rasCount_q + CW'(1);
            end
        end else if (rasPop && !rasPush) begin
            rasTos_q   <= rasTos_q - PW'(1);
            rasCount_q <= rasCount_q - CW'(1);
        end
    end

    // Return-address storage; overflow naturally overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst && rasPush) begin
            rasMem_q[rasWrIdx] <= callLink;
        end
    end
`else
    localparam int unusedRasDepth = RAS_DEPTH;
    logic unusedRasSignals;

    assign rasPopOk         = 1'b0;
    assign rasTop           = '0;
    assign unusedRasSignals = ^{bus.id_call, bus.id_ret_en, rasFlush,
                                idAccept, callLink};
`endif

    // Next-PC selection by priority: trap, ex, RAS return, JAL, sequential.
    always_comb begin
        pcAddr_d       = pcAddr_q;
        redirect_d     = 1'b0;
        misalignErr_d  = 1'b0;
        misalignAddr_d = misalignAddr_q;
        rasHit_d       = 1'b0;
        rasFlush       = 1'b0;
        idAccept       = 1'b0;
        if (bus.trap_en) begin
            pcAddr_d   = bus.trap_addr & TRAP_MASK;
            redirect_d = 1'b1;
            rasFlush   = 1'b1;
        end else if (bus.ex_redir_en) begin
            rasFlush = 1'b1;
            if (exTarget[1]) begin
                misalignErr_d  = 1'b1;
                misalignAddr_d = exTarget;
            end else begin
                pcAddr_d   = exTarget;
                redirect_d = 1'b1;
            end
        end else if (bus.pc_en) begin
            idAccept = 1'b1;
            if (rasPopOk) begin
                pcAddr_d   = rasTop;
                redirect_d = 1'b1;
                rasHit_d   = 1'b1;
            end else if (bus.id_jal_en) begin
                if (idTarget[1]) begin
                    misalignErr_d  = 1'b1;
                    misalignAddr_d = idTarget;
                end else begin
                    pcAddr_d   = idTarget;
                    redirect_d = 1'b1;
                end
            end else begin
                pcAddr_d = pcAddr_q + XLEN'(4);
            end
        end
    end

    // Output registers; reset wins over every request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcAddr_q       <= RESET_VEC;
            redirect_q     <= 1'b0;
            misalignErr_q  <= 1'b0;
            misalignAddr_q <= '0;
            rasHit_q       <= 1'b0;
        end else begin
            pcAddr_q       <= pcAddr_d;
            redirect_q     <= redirect_d;
            misalignErr_q  <= misalignErr_d;
            misalignAddr_q <= misalignAddr_d;
            rasHit_q       <= rasHit_d;
        end
    end

    assign bus.pc_addr       = pcAddr_q;
    assign bus.redirect      = redirect_q;
    assign bus.misalign_err  = misalignErr_q;
    assign bus.misalign_addr = misalignAddr_q;
    assign bus.ras_hit       = rasHit_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with a scoreboard queue.
// Expectations follow PC_GEN_RAS_EN so the same bench covers both builds.
module tb_pc_gen;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        redir;
        logic        err;
        logic [31:0] maddr;
        logic        hit;
    } exp_t;

    logic clk;
    logic rst;
    exp_t expQ[$];
    int   checks;
    int   errors;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next edge, then return all inputs to an idle default.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        rst             = 1'b1;
        bus.pc_en       = 1'b0;
        bus.trap_en     = 1'b0;
        bus.trap_addr   = '0;
        bus.ex_redir_en = 1'b0;
        bus.ex_jalr     = 1'b0;
        bus.ex_pc       = '0;
        bus.ex_rs1      = '0;
        bus.ex_off      = '0;
        bus.id_jal_en   = 1'b0;
        bus.id_pc       = '0;
        bus.id_off      = '0;
        bus.id_call     = 1'b0;
        bus.id_ret_en   = 1'b0;
    endtask

    task automatic expectNext(input string name, input logic [31:0] pc,
                              input logic redir, input logic err,
                              input logic [31:0] maddr, input logic hit);
        exp_t e;
        e.name  = name;
        e.pc    = pc;
        e.redir = redir;
        e.err   = err;
        e.maddr = maddr;
        e.hit   = hit;
        expQ.push_back(e);
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s %s got %h want %h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.name, "pc_addr", bus.pc_addr, e.pc);
        compareField(e.name, "redirect", {31'b0, bus.redirect}, {31'b0, e.redir});
        compareField(e.name, "misalign_err", {31'b0, bus.misalign_err}, {31'b0, e.err});
        compareField(e.name, "misalign_addr", bus.misalign_addr, e.maddr);
        compareField(e.name, "ras_hit", {31'b0, bus.ras_hit}, {31'b0, e.hit});
    endtask

    // Monitor: one expectation per cycle, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    logic [31:0] retPc  [5];
    logic        retHit [5];
    logic [31:0] pairPc [3];
    logic        pairRedir [3];
    logic        pairHit [3];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
`ifdef PC_GEN_RAS_EN
        retPc  = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h28};
        retHit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pairPc    = '{32'h64, 32'h74, 32'h78};
        pairRedir = '{1'b1, 1'b1, 1'b0};
        pairHit   = '{1'b1, 1'b1, 1'b0};
`else
        retPc  = '{32'h454, 32'h458, 32'h45C, 32'h460, 32'h464};
        retHit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pairPc    = '{32'h464, 32'h468, 32'h46C};
        pairRedir = '{1'b0, 1'b0, 1'b0};
        pairHit   = '{1'b0, 1'b0, 1'b0};
`endif

        // Reset overrides a simultaneous trap request.
        applyStimulus(); rst = 1'b0; bus.pc_en = 1'b1; bus.trap_en = 1'b1;
        bus.trap_addr = 32'h40;
        expectNext("reset", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(); bus.pc_en = 1'b1;
            expectNext("seq", 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
        end

        applyStimulus();
        expectNext("stall", 32'hC, 1'b0, 1'b0, 32'h0, 1'b0);

        applyStimulus(); bus.trap_en = 1'b1; bus.trap_addr = 32'h100;
        expectNext("trap100", 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus(); bus.ex_redir_en = 1'b1; bus.ex_pc = 32'hF8;
        bus.ex_off = 13'h1FF8;
        expectNext("exBranchStalled", 32'hF0, 1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus();
        expectNext("pulseEnd", 32'hF0, 1'b0, 1'b0, 32'h0, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.trap_en = 1'b1;
        bus.trap_addr = 32'h203; bus.ex_redir_en = 1'b1; bus.ex_pc = 32'h500;
        bus.ex_off = 13'h10; bus.id_jal_en = 1'b1; bus.id_pc = 32'h600;
        bus.id_off = 21'h20;
        expectNext("trapPriority", 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.ex_redir_en = 1'b1;
        bus.ex_jalr = 1'b1; bus.ex_rs1 = 32'h1001; bus.ex_off = 13'h2;
        expectNext("exJalrMisalign", 32'h200, 1'b0, 1'b1, 32'h1002, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1;
        expectNext("afterMisalign", 32'h204, 1'b0, 1'b0, 32'h1002, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
        bus.id_pc = 32'h204; bus.id_off = 21'h100;
        expectNext("jal", 32'h304, 1'b1, 1'b0, 32'h1002, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
        bus.id_pc = 32'h304; bus.id_off = 21'h2;
        expectNext("jalMisalign", 32'h304, 1'b0, 1'b1, 32'h306, 1'b0);

        applyStimulus(); bus.id_jal_en = 1'b1; bus.id_pc = 32'h304;
        bus.id_off = 21'h100;
        expectNext("jalStalled", 32'h304, 1'b0, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.ex_redir_en = 1'b1; bus.ex_jalr = 1'b1;
        bus.ex_rs1 = 32'h2000; bus.ex_off = 13'h1;
        expectNext("exJalrBit0", 32'h2000, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
        bus.id_pc = 32'h2000; bus.id_off = 21'h1FF000;
        expectNext("jalNegative", 32'h1000, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.ex_redir_en = 1'b1; bus.ex_pc = 32'h0;
        bus.ex_off = 13'h1FFC;
        expectNext("exWrap", 32'hFFFFFFFC, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1;
        expectNext("seqWrap", 32'h0, 1'b0, 1'b0, 32'h306, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
            bus.id_call = 1'b1; bus.id_pc = 32'(16 * i); bus.id_off = 21'h400;
            expectNext("call", 32'h400 + 32'(16 * i), 1'b1, 1'b0, 32'h306, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(); bus.pc_en = 1'b1; bus.id_ret_en = 1'b1;
            bus.id_pc = 32'h500;
            expectNext("ret", retPc[i], retHit[i], 1'b0, 32'h306, retHit[i]);
        end

        applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
        bus.id_call = 1'b1; bus.id_pc = 32'h60; bus.id_off = 21'h400;
        expectNext("call60", 32'h460, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.id_ret_en = 1'b1;
        bus.id_call = 1'b1; bus.id_pc = 32'h70;
        expectNext("popPush", pairPc[0], pairRedir[0], 1'b0, 32'h306, pairHit[0]);

        for (int i = 1; i < 3; i++) begin
            applyStimulus(); bus.pc_en = 1'b1; bus.id_ret_en = 1'b1;
            bus.id_pc = 32'h700;
            expectNext("retAfterPair", pairPc[i], pairRedir[i], 1'b0, 32'h306, pairHit[i]);
        end

        applyStimulus(); bus.pc_en = 1'b1; bus.id_jal_en = 1'b1;
        bus.id_call = 1'b1; bus.id_pc = 32'h80; bus.id_off = 21'h400;
        expectNext("call80", 32'h480, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.trap_en = 1'b1; bus.trap_addr = 32'h300;
        expectNext("trapFlush", 32'h300, 1'b1, 1'b0, 32'h306, 1'b0);

        applyStimulus(); bus.pc_en = 1'b1; bus.id_ret_en = 1'b1;
        bus.id_pc = 32'h900;
        expectNext("retAfterFlush", 32'h304, 1'b0, 1'b0, 32'h306, 1'b0);

        applyStimulus();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator; the next generation of the core's PC register. Selects the next fetch address each cycle from trap vector, execute-stage branch/JALR resolution, decode-stage JAL, or sequential increment, using the redirecting instruction's own PC rather than fixed pipeline-offset correction. Flags misaligned targets and emits a flush pulse. Optionally predicts returns with a return-address stack. Sits between the CSR/trap unit, the decode and execute stages, and the instruction-fetch port.

## Interface
- XLEN, 32: address width; 32 or 64.
- RESET_VEC, 0: value loaded into pc_addr on reset.
- RAS_DEPTH, 4: return-address-stack entries; power of two, 2..16. Used only with PC_GEN_RAS_EN.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- pc_en  in  1  fetch advance enable; 0 = fetch stalled.
- trap_en  in  1  trap/return redirect request.
- trap_addr  in  XLEN  trap target; bits [1:0] forced to 0.
- ex_redir_en  in  1  execute-stage taken branch or JALR.
- ex_jalr  in  1  1 = JALR (base ex_rs1), 0 = branch (base ex_pc).
- ex_pc  in  XLEN  PC of the redirecting execute instruction.
- ex_rs1  in  XLEN  JALR base register value.
- ex_off  in  13  signed offset; branch offset is B-imm, JALR offset is I-imm sign-extended to 13 bits.
- id_jal_en  in  1  decode-stage JAL.
- id_pc  in  XLEN  PC of the decode instruction.
- id_off  in  21  signed J-immediate.
- id_call  in  1  decode JAL/JALR with rd in {x1,x5}; qualifies a RAS push.
- id_ret_en  in  1  decode JALR x0,0(x1/x5); qualifies a RAS pop.
- pc_addr  out  XLEN  current fetch PC (registered).
- redirect  out  1  one-cycle pulse: pc_addr was loaded from a non-sequential source last edge.
- misalign_err  out  1  one-cycle pulse: requested target was misaligned and was dropped.
- misalign_addr  out  XLEN  offending target, held until the next error.
- ras_hit  out  1  one-cycle pulse: last redirect came from the RAS.

## Operation
- Source priority, highest first: trap, ex, id_ret (RAS), id_jal, sequential.
- trap and ex take effect regardless of pc_en; id_ret, id_jal and sequential only when pc_en=1.
- Target arithmetic is modulo 2^XLEN. Offsets are sign-extended to XLEN:
  - trap: trap_addr & ~3.
  - ex branch: ex_pc + sext(ex_off).
  - ex JALR: (ex_rs1 + sext(ex_off)) & ~1.
  - id_jal: id_pc + sext(id_off).
  - sequential: pc_addr + 4.
- Misalign check applies to the ex and id_jal targets. If target[1] is 1:
  - pc_addr holds its value; redirect=0.
  - misalign_err pulses and misalign_addr takes the target.
  - Lower-priority sources are not used that cycle.
- When pc_en=0 and no trap/ex request is present, pc_addr holds.
- RAS, only with macro:
  - Circular stack with tos pointer and count (0..RAS_DEPTH).
  - Push: id_jal_en & id_call accepted pushes id_pc+4.
  - Pop: id_ret_en accepted with count>0 redirects to the top entry, pops it, and pulses ras_hit.
  - Pop on empty: no prediction; falls through to id_jal or sequential.
  - Overflow: a push when full overwrites the oldest entry; count saturates.
  - Simultaneous pop and push (id_ret_en & id_call): the top entry is replaced by id_pc+4 and count is unchanged. Redirect goes to the old top.
  - Any trap or ex redirect flushes the RAS: count=0.

## Timing
- Reset at posedge with rst=0:
  - pc_addr=RESET_VEC.
  - redirect=0, misalign_err=0, ras_hit=0.
  - misalign_addr=0, RAS count=0, tos=0.
- Reset overrides every request in the same cycle.
- Latency: a request sampled at edge N appears on pc_addr, redirect, misalign_err and ras_hit after edge N; pulses last exactly one cycle.
- No combinational path from inputs to outputs.

## Configuration
- PC_GEN_RAS_EN defined: RAS built as described.
- PC_GEN_RAS_EN not defined: no RAS storage; id_call and id_ret_en are ignored; ras_hit tied to 0; all other behaviour identical.

## Test plan
- Reset, then pc_en=1 for 3 cycles -> pc_addr 0, 4, 8, 0xC; redirect stays 0.
- pc_addr=0x100, pc_en=0, ex_redir_en=1, ex_jalr=0, ex_pc=0xF8, ex_off=-8 -> pc_addr=0xF0, redirect pulses 1 cycle.
- trap_en=1 with trap_addr=0x203, ex_redir_en=1 and id_jal_en=1 in the same cycle -> pc_addr=0x200; RAS count becomes 0.
- ex_jalr=1, ex_rs1=0x1001, ex_off=2 -> target 0x1003&~1=0x1002 is misaligned -> pc_addr holds, misalign_err=1, misalign_addr=0x1002.
- Macro on, RAS_DEPTH=4: 5 calls from id_pc 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns -> redirects to 0x54, 0x44, 0x34, 0x24 with ras_hit each time; 5th return gives no ras_hit and pc_addr advances by 4.
- Macro off: same stimulus -> ras_hit always 0; returns advance pc_addr by 4.
